// File: rtl/cache_if.sv
// cache_if: bundle between the processor / RAM side and the cache controller.
//   Processor request : req, rwb, addr, wdata
//   Processor response: ready, rdata, hit
//   RAM access        : mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//   Statistics        : hit_count, miss_count
// The slave modport is the controller's view; the master modport is the
// view of whoever drives requests and models the RAM.
interface cache_if #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int CW = 16
) ();
  logic          req;
  logic          rwb;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          hit;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  modport slave (
    input  req, rwb, addr, wdata, mem_rdata, mem_ack,
    output ready, rdata, hit, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  modport master (
    output req, rwb, addr, wdata, mem_rdata, mem_ack,
    input  ready, rdata, hit, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way set-associative write-back cache controller, one byte
// per line. Accepts one read/write request at a time, looks up the tag,
// evicts the LRU (or first invalid) way on a miss with writeback when dirty,
// refills on read misses and allocates without refill on write misses.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-low reset
//   bus   - cache_if.slave: processor request/response, RAM port, counters
// All outputs are registered; ready/hit/rdata form a one-cycle pulse.
module cache_ctrl #(
  parameter int AW   = 6,
  parameter int DW   = 8,
  parameter int SETS = 8,
  parameter int CW   = 16
) (
  input  logic  clk,
  input  logic  reset,
  cache_if.slave bus
);
  localparam int IW = 3;
  localparam int TW = AW - IW;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state, state_n;

  // latched request and lookup result
  logic          rwb_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          hit_q;
  logic          way_q;

  // line storage; valid/dirty/lru are control and get reset, tag/data do not
  logic [1:0][SETS-1:0] valid;
  logic [1:0][SETS-1:0] dirty;
  logic [SETS-1:0]      lru;
  logic [TW-1:0]        tag_mem  [2][SETS];
  logic [DW-1:0]        data_mem [2][SETS];

  // registered outputs and their next values
  logic          ready_r, ready_n;
  logic          hit_r, hit_n;
  logic [DW-1:0] rdata_r, rdata_n;
  logic          mem_req_r, mem_req_n;
  logic          mem_we_r, mem_we_n;
  logic [AW-1:0] mem_addr_r, mem_addr_n;
  logic [DW-1:0] mem_wdata_r, mem_wdata_n;
  logic [CW-1:0] hit_count_r, miss_count_r;

  logic [IW-1:0] idx;
  logic [TW-1:0] tg;
  logic          hit0, hit1, hit_any, victim;

  assign idx     = addr_q[IW-1:0];
  assign tg      = addr_q[AW-1:IW];
  assign hit0    = valid[0][idx] && (tag_mem[0][idx] == tg);
  assign hit1    = valid[1][idx] && (tag_mem[1][idx] == tg);
  assign hit_any = hit0 || hit1;
  // way0 preferred when invalid, then way1, otherwise the LRU way
  assign victim  = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

  always_comb begin
    state_n     = state;
    ready_n     = 1'b0;
    hit_n       = 1'b0;
    rdata_n     = '0;
    mem_req_n   = mem_req_r;
    mem_we_n    = mem_we_r;
    mem_addr_n  = mem_addr_r;
    mem_wdata_n = mem_wdata_r;
    case (state)
      IDLE: if (bus.req) state_n = LOOKUP;
      LOOKUP: begin
        if (hit_any) begin
          state_n = RESPOND;
        end else if (valid[victim][idx] && dirty[victim][idx]) begin
          state_n     = WRITEBACK;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = {tag_mem[victim][idx], idx};
          mem_wdata_n = data_mem[victim][idx];
        end else if (!rwb_q) begin
          state_n    = REFILL;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = addr_q;
        end else begin
          // write miss: the whole line is overwritten, no refill needed
          state_n = RESPOND;
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack) begin
          if (!rwb_q) begin
            state_n    = REFILL;
            mem_we_n   = 1'b0;
            mem_addr_n = addr_q;
          end else begin
            state_n   = RESPOND;
            mem_req_n = 1'b0;
          end
        end
      end
      REFILL: begin
        if (bus.mem_ack) begin
          state_n   = RESPOND;
          mem_req_n = 1'b0;
        end
      end
      RESPOND: begin
        state_n = IDLE;
        ready_n = 1'b1;
        hit_n   = hit_q;
        rdata_n = rwb_q ? '0 : data_mem[way_q][idx];
      end
      default: state_n = IDLE;
    endcase
  end

  // control state: FSM, outputs, line status bits, counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ready_r      <= 1'b0;
      hit_r        <= 1'b0;
      rdata_r      <= '0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      valid        <= '0;
      dirty        <= '0;
      lru          <= '0;
      hit_count_r  <= '0;
      miss_count_r <= '0;
    end else begin
      state       <= state_n;
      ready_r     <= ready_n;
      hit_r       <= hit_n;
      rdata_r     <= rdata_n;
      mem_req_r   <= mem_req_n;
      mem_we_r    <= mem_we_n;
      mem_addr_r  <= mem_addr_n;
      mem_wdata_r <= mem_wdata_n;
      if (state == WRITEBACK && bus.mem_ack) valid[way_q][idx] <= 1'b0;
      if (state == REFILL && bus.mem_ack) begin
        valid[way_q][idx] <= 1'b1;
        dirty[way_q][idx] <= 1'b0;
      end
      if (state == RESPOND) begin
        if (rwb_q) begin
          valid[way_q][idx] <= 1'b1;
          dirty[way_q][idx] <= 1'b1;
        end
        lru[idx] <= ~way_q;
        if (hit_q) begin
          if (hit_count_r != {CW{1'b1}}) hit_count_r <= hit_count_r + CW'(1);
        end else begin
          if (miss_count_r != {CW{1'b1}}) miss_count_r <= miss_count_r + CW'(1);
        end
      end
    end
  end

  // data state: request latch, lookup result, tag/data arrays
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      rwb_q   <= bus.rwb;
      addr_q  <= bus.addr;
      wdata_q <= bus.wdata;
    end
    if (state == LOOKUP) begin
      hit_q <= hit_any;
      way_q <= hit_any ? hit1 : victim;
    end
    if (state == REFILL && bus.mem_ack) begin
      data_mem[way_q][idx] <= bus.mem_rdata;
      tag_mem[way_q][idx]  <= tg;
    end
    if (state == RESPOND && rwb_q) begin
      data_mem[way_q][idx] <= wdata_q;
      tag_mem[way_q][idx]  <= tg;
    end
  end

  assign bus.ready      = ready_r;
  assign bus.hit        = hit_r;
  assign bus.rdata      = rdata_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.hit_count  = hit_count_r;
  assign bus.miss_count = miss_count_r;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scoreboard bench for cache_ctrl.
// Requests push their expected response into a queue that a negedge monitor
// pops whenever ready is seen; a RAM model acknowledges mem_req after a
// programmable delay and checks each transfer against an expected-transfer
// queue. Counters are 2 bits wide so saturation is reached quickly.
module tb_cache_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int CW = 2;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          hit;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  rsp_t sb[$];
  mem_t mexp[$];
  logic [DW-1:0] ram [64];
  int   ack_dly = 0;
  logic [CW-1:0] hc_m = '0;
  logic [CW-1:0] mc_m = '0;

  cache_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  cache_ctrl #(.AW(AW), .DW(DW), .SETS(8), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // response monitor
  always @(negedge clk) begin
    if (reset && bus.ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rdata", 32'(bus.rdata), 32'(e.rdata));
        chk("hit", 32'(bus.hit), 32'(e.hit));
        chk("hit_count", 32'(bus.hit_count), 32'(e.hc));
        chk("miss_count", 32'(bus.miss_count), 32'(e.mc));
      end
    end
  end

  // RAM model: ack after ack_dly cycles of mem_req, check hold and transfer
  initial begin
    int            wait_cnt;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end else begin
        if (wait_cnt == 0) begin
          cap_we    = bus.mem_we;
          cap_addr  = bus.mem_addr;
          cap_wdata = bus.mem_wdata;
        end else begin
          chk("mem_hold_we", 32'(bus.mem_we), 32'(cap_we));
          chk("mem_hold_addr", 32'(bus.mem_addr), 32'(cap_addr));
          if (cap_we) chk("mem_hold_wdata", 32'(bus.mem_wdata), 32'(cap_wdata));
        end
        if (wait_cnt >= ack_dly) begin
          bus.mem_ack = 1'b1;
          wait_cnt    = 0;
          if (mexp.size() == 0) begin
            chk("unexpected_mem_req", 32'(bus.mem_addr), 32'hFFFF);
          end else begin
            mem_t m;
            m = mexp.pop_front();
            chk("mem_we", 32'(bus.mem_we), 32'(m.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
            if (m.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
          end
          if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata    = ram[bus.mem_addr];
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end
    end
  end

  // called on a negedge with the DUT idle; returns on the negedge showing ready
  task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] er, input logic eh, input int lat);
    int n;
    if (eh) hc_m = sat(hc_m);
    else    mc_m = sat(mc_m);
    sb.push_back('{rdata: er, hit: eh, hc: hc_m, mc: mc_m});
    bus.req   = 1'b1;
    bus.rwb   = rw;
    bus.addr  = a;
    bus.wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    n = 1;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency_%s_%02h", rw ? "wr" : "rd", a), 32'(bus.ready ? n : 0), 32'(lat));
  endtask

  task automatic exp_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mexp.push_back('{we: we, addr: a, wdata: d});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) ram[i] = 8'h80 + 8'(i);
    ram[5]    = 8'h3C;
    reset     = 1'b0;
    bus.req   = 1'b0;
    bus.rwb   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
    chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // read miss with immediate ack, then repeat hit
    exp_mem(1'b0, 6'h05, 8'h00);
    do_req(1'b0, 6'h05, 8'h00, 8'h3C, 1'b0, 4);
    do_req(1'b0, 6'h05, 8'h00, 8'h3C, 1'b1, 3);
    // write-miss allocate without RAM, then hit
    do_req(1'b1, 6'h02, 8'h11, 8'h00, 1'b0, 3);
    do_req(1'b0, 6'h02, 8'h00, 8'h11, 1'b1, 3);
    // fill set 1, touch way0, evict dirty way1 (0x09)
    do_req(1'b1, 6'h01, 8'hA1, 8'h00, 1'b0, 3);
    do_req(1'b1, 6'h09, 8'hB9, 8'h00, 1'b0, 3);
    do_req(1'b0, 6'h01, 8'h00, 8'hA1, 1'b1, 3);
    exp_mem(1'b1, 6'h09, 8'hB9);
    do_req(1'b1, 6'h19, 8'hC9, 8'h00, 1'b0, 4);
    do_req(1'b0, 6'h01, 8'h00, 8'hA1, 1'b1, 3);
    do_req(1'b0, 6'h19, 8'h00, 8'hC9, 1'b1, 3);
    // read miss with dirty victim: writeback 0x01 then refill 0x09
    exp_mem(1'b1, 6'h01, 8'hA1);
    exp_mem(1'b0, 6'h09, 8'h00);
    do_req(1'b0, 6'h09, 8'h00, 8'hB9, 1'b0, 5);
    // delayed ack on refill
    ack_dly = 5;
    exp_mem(1'b0, 6'h0D, 8'h00);
    do_req(1'b0, 6'h0D, 8'h00, 8'h8D, 1'b0, 9);

    // reset in the middle of a writeback of 0x19
    ack_dly   = 30;
    bus.req   = 1'b1;
    bus.rwb   = 1'b1;
    bus.addr  = 6'h11;
    bus.wdata = 8'hD1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_started", 32'(bus.mem_req && bus.mem_we), 32'd1);
    chk("wb_addr", 32'(bus.mem_addr), 32'h19);
    chk("wb_wdata", 32'(bus.mem_wdata), 32'hC9);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd0);
    chk("abort_hit_count", 32'(bus.hit_count), 32'd0);
    chk("abort_miss_count", 32'(bus.miss_count), 32'd0);
    reset   = 1'b1;
    hc_m    = '0;
    mc_m    = '0;
    ack_dly = 0;
    mexp.delete();
    @(negedge clk);
    // everything misses after reset; 0x19 was never written back
    exp_mem(1'b0, 6'h05, 8'h00);
    do_req(1'b0, 6'h05, 8'h00, 8'h3C, 1'b0, 4);
    exp_mem(1'b0, 6'h19, 8'h00);
    do_req(1'b0, 6'h19, 8'h00, 8'h99, 1'b0, 4);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("mem_drained", 32'(mexp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
